regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port wr_en_i, input, 1, writeback strobe.
REQ-007 SHALL have port wr_addr_i, input, AW, writeback destination register.
REQ-008 SHALL have port wr_data_i, input, XLEN, writeback data.
REQ-009 SHALL have port resv_en_i, input, 1, reserve request marking a destination pending.
REQ-010 SHALL have port resv_addr_i, input, AW, register to reserve.
REQ-011 SHALL have port rd_addr_i, input, NRD*AW, packed read addresses, port k at bits [k*AW +: AW].
REQ-012 SHALL have port rd_data_o, output, NRD*XLEN, packed read data, combinational from rd_addr_i.
REQ-013 SHALL have port rd_busy_o, output, NRD, per-port pending flag of the addressed register.
REQ-014 SHALL have port hazard_o, output, 1, OR of rd_busy_o and of busy[resv_addr_i] when resv_en_i.
REQ-015 SHALL have port busy_cnt_o, output, AW+1, registered count of pending registers.

Function
REQ-016 SHALL hold NREGS x XLEN storage plus one busy bit per register.
REQ-017 SHALL hardwire register 0: reads return 0, writes ignored, never busy, never counted.
REQ-018 SHALL write wr_data_i into wr_addr_i on the rising edge when wr_en_i=1 and wr_addr_i!=0.
REQ-019 SHALL set busy[resv_addr_i] on the edge when resv_en_i=1, resv_addr_i!=0.
REQ-020 SHALL clear busy[wr_addr_i] on the edge when wr_en_i=1, regardless of prior busy state.
REQ-021 SHALL, when reserve and writeback hit the same register in one cycle, store the data and leave busy set (reserve wins).
REQ-022 SHALL accept reserve of an already-busy register: busy stays 1, count unchanged, hazard_o=1 that cycle.
REQ-023 SHALL update busy_cnt_o by +1, -1 or 0 per edge from actual busy-bit transitions; never wraps, max NREGS-1.
REQ-024 SHALL drive rd_data_o and rd_busy_o combinationally with zero-cycle read latency.
REQ-025 SHALL return identical data on all ports addressing the same register in one cycle.
REQ-026 SHALL report rd_busy_o[k]=0 when the same-cycle writeback clears that register and it is not re-reserved.

Reset
REQ-027 SHALL, on rising edge with rst=1, clear all registers to 0, all busy bits, and busy_cnt_o to 0.
REQ-028 SHALL give rst priority over wr_en_i and resv_en_i in the same cycle; mid-operation reservations are discarded.
REQ-029 SHALL keep outputs combinationally consistent with reset state from the first edge after rst asserts.

Configuration
REQ-030 SHALL use macro REGFILE_BYPASS_EN to select read-during-write behaviour.
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, forward wr_data_i to any read port whose address equals a same-cycle nonzero wr_addr_i with wr_en_i=1.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return the pre-edge stored value on a same-cycle read of the written register.

Verification
REQ-033 SHALL cover: rst=1 one edge, then read all 32 addresses -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
REQ-034 SHALL cover: write x13=0x00FF00FF, x10=0x11FF11FF, read ports (13,10) -> 0x00FF00FF, 0x11FF11FF; write x0=0xFFFF0000 -> x0 reads 0.
REQ-035 SHALL cover: reserve x23 -> next cycle rd_busy_o=1 on port reading 23, hazard_o=1, busy_cnt_o=1; writeback x23=0xDEADBEEF -> busy cleared, count 0, data 0xDEADBEEF.
REQ-036 SHALL cover: reserve and writeback x5 same cycle with 0x12345678 -> x5=0x12345678, busy[5]=1, count 1; reserve x5 again -> count stays 1.
REQ-037 SHALL cover: same-cycle write x7=0xCAFEF00D and read x7 (old 0) -> 0xCAFEF00D with REGFILE_BYPASS_EN, 0 without.
REQ-038 SHALL cover: reserve x1..x31 over 31 cycles -> busy_cnt_o=31; assert rst -> all busy cleared, count 0, registers 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register busy (scoreboard) bits and a pending-register count.
// Latency: reads are combinational (zero cycles); writes, reserves and the count update on the rising edge.
// Backpressure: none; hazard_o flags reads or reserves of pending registers, and the issuing logic decides whether to stall.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [XLEN-1:0]     wr_data_i,
   input  logic                resv_en_i,
   input  logic [AW-1:0]       resv_addr_i,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   output logic                hazard_o,
   output logic [AW:0]         busy_cnt_o
);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      busy_cnt;
   logic             cnt_inc;
   logic             cnt_dec;
   logic             wr_live;
   logic             resv_live;
   logic             resv_wr_same;

   assign wr_live      = wr_en_i && (wr_addr_i != '0);
   assign resv_live    = resv_en_i && (resv_addr_i != '0);
   assign resv_wr_same = resv_en_i && (resv_addr_i == wr_addr_i);

   // Next busy vector: writeback clears, reserve sets afterwards so reserve wins; x0 is never pending.
   always_comb begin
      busy_nxt = busy;
      if (wr_en_i) begin
         busy_nxt[wr_addr_i] = 1'b0;
      end
      if (resv_en_i) begin
         busy_nxt[resv_addr_i] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Count only real 0->1 and 1->0 transitions so re-reserves and writes of idle registers do not move it.
   assign cnt_inc = resv_live && !busy[resv_addr_i];
   assign cnt_dec = wr_live && busy[wr_addr_i] && !resv_wr_same;

   // Storage update: reset clears everything and overrides any same-cycle write or reserve.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_live) begin
            regs[wr_addr_i] <= wr_data_i;
         end
         busy     <= busy_nxt;
         busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
      end
   end

   assign busy_cnt_o = busy_cnt;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          wr_hit;
      logic          resv_hit;

      assign ra       = rd_addr_i[k*AW +: AW];
      assign wr_hit   = wr_live && (wr_addr_i == ra);
      assign resv_hit = resv_en_i && (resv_addr_i == ra);

      // A same-cycle writeback retires the pending value unless the same register is re-reserved.
      assign rd_busy_o[k] = busy[ra] && !(wr_hit && !resv_hit);

`ifdef REGFILE_BYPASS_EN
      // Read data with writeback forwarding; x0 always reads zero.
      assign rd_data_o[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         wr_hit     ? wr_data_i : regs[ra];
`else
      // Read data returns the pre-edge stored value; x0 always reads zero.
      assign rd_data_o[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
`endif
   end

   assign hazard_o = (|rd_busy_o) || (resv_en_i && busy[resv_addr_i]);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                resv_en;
   logic [AW-1:0]       resv_addr;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                hazard;
   logic [AW:0]         busy_cnt;

   int tests = 0;
   int fails = 0;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .resv_en_i  (resv_en),
      .resv_addr_i(resv_addr),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_busy_o  (rd_busy),
      .hazard_o   (hazard),
      .busy_cnt_o (busy_cnt)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and let outputs settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask

   task automatic idle_inputs();
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      resv_en   = 1'b0;
      resv_addr = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      for (int a = 0; a < NREGS; a++) begin
         set_rd(AW'(a), AW'(NREGS - 1 - a));
         tests++;
         if (rd_data !== '0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_read addr=%0d got data=%h busy=%b want data=0 busy=00", a, rd_data, rd_busy);
         end
      end
      tests++;
      if (busy_cnt !== 6'd0 || hazard !== 1'b0) begin
         fails++;
         $display("FAIL reset_cnt got cnt=%0d hazard=%b want cnt=0 hazard=0", busy_cnt, hazard);
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h00FF00FF;
      tick();
      wr_addr = 5'd10; wr_data = 32'h11FF11FF;
      tick();
      idle_inputs();
      set_rd(5'd13, 5'd10);
      tests++;
      if (rd_data[31:0] !== 32'h00FF00FF || rd_data[63:32] !== 32'h11FF11FF) begin
         fails++;
         $display("FAIL write_read got p0=%h p1=%h want p0=00ff00ff p1=11ff11ff", rd_data[31:0], rd_data[63:32]);
      end
      set_rd(5'd13, 5'd13);
      tests++;
      if (rd_data[31:0] !== 32'h00FF00FF || rd_data[63:32] !== 32'h00FF00FF) begin
         fails++;
         $display("FAIL same_addr got p0=%h p1=%h want both 00ff00ff", rd_data[31:0], rd_data[63:32]);
      end
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF0000;
      tick();
      idle_inputs();
      set_rd(5'd0, 5'd10);
      tests++;
      if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h11FF11FF) begin
         fails++;
         $display("FAIL x0_write got p0=%h p1=%h want p0=0 p1=11ff11ff", rd_data[31:0], rd_data[63:32]);
      end
      tests++;
      if (busy_cnt !== 6'd0) begin
         fails++;
         $display("FAIL write_no_count got cnt=%0d want 0", busy_cnt);
      end
   endtask

   task automatic test_reserve_writeback();
      resv_en = 1'b1; resv_addr = 5'd23;
      tick();
      idle_inputs();
      set_rd(5'd0, 5'd23);
      tests++;
      if (rd_busy !== 2'b10 || hazard !== 1'b1 || busy_cnt !== 6'd1) begin
         fails++;
         $display("FAIL reserve got busy=%b hazard=%b cnt=%0d want busy=10 hazard=1 cnt=1", rd_busy, hazard, busy_cnt);
      end
      wr_en = 1'b1; wr_addr = 5'd23; wr_data = 32'hDEADBEEF;
      #1;
      tests++;
      if (rd_busy !== 2'b00 || hazard !== 1'b0) begin
         fails++;
         $display("FAIL wb_clear_same_cycle got busy=%b hazard=%b want busy=00 hazard=0", rd_busy, hazard);
      end
      tick();
      idle_inputs();
      #1;
      tests++;
      if (rd_busy !== 2'b00 || busy_cnt !== 6'd0 || rd_data[63:32] !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL writeback got busy=%b cnt=%0d data=%h want busy=00 cnt=0 data=deadbeef", rd_busy, busy_cnt, rd_data[63:32]);
      end
   endtask

   task automatic test_resv_wr_same_cycle();
      resv_en = 1'b1; resv_addr = 5'd5;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
      tick();
      idle_inputs();
      set_rd(5'd5, 5'd0);
      tests++;
      if (rd_data[31:0] !== 32'h12345678 || rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
         fails++;
         $display("FAIL resv_wins got data=%h busy=%b cnt=%0d want data=12345678 busy=01 cnt=1", rd_data[31:0], rd_busy, busy_cnt);
      end
      set_rd(5'd0, 5'd0);
      resv_en = 1'b1; resv_addr = 5'd5;
      #1;
      tests++;
      if (hazard !== 1'b1) begin
         fails++;
         $display("FAIL rereserve_hazard got hazard=%b want 1", hazard);
      end
      tick();
      idle_inputs();
      #1;
      tests++;
      if (busy_cnt !== 6'd1) begin
         fails++;
         $display("FAIL rereserve_cnt got cnt=%0d want 1", busy_cnt);
      end
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0055;
      tick();
      idle_inputs();
      set_rd(5'd5, 5'd0);
      tests++;
      if (busy_cnt !== 6'd0 || rd_busy !== 2'b00 || rd_data[31:0] !== 32'h0000_0055) begin
         fails++;
         $display("FAIL release_x5 got cnt=%0d busy=%b data=%h want cnt=0 busy=00 data=00000055", busy_cnt, rd_busy, rd_data[31:0]);
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp;
      exp = BYPASS ? 32'hCAFEF00D : 32'h0;
      set_rd(5'd7, 5'd13);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D;
      #1;
      tests++;
      if (rd_data[31:0] !== exp || rd_data[63:32] !== 32'h00FF00FF) begin
         fails++;
         $display("FAIL rdw_x7 got p0=%h p1=%h want p0=%h p1=00ff00ff", rd_data[31:0], rd_data[63:32], exp);
      end
      tick();
      idle_inputs();
      #1;
      tests++;
      if (rd_data[31:0] !== 32'hCAFEF00D) begin
         fails++;
         $display("FAIL x7_after got %h want cafef00d", rd_data[31:0]);
      end
   endtask

   task automatic test_fill_and_reset();
      for (int a = 1; a < NREGS; a++) begin
         resv_en = 1'b1; resv_addr = AW'(a);
         tick();
      end
      idle_inputs();
      set_rd(5'd31, 5'd1);
      tests++;
      if (busy_cnt !== 6'd31 || rd_busy !== 2'b11) begin
         fails++;
         $display("FAIL fill got cnt=%0d busy=%b want cnt=31 busy=11", busy_cnt, rd_busy);
      end
      rst = 1'b1;
      resv_en = 1'b1; resv_addr = 5'd3;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      tick();
      rst = 1'b0;
      idle_inputs();
      #1;
      tests++;
      if (busy_cnt !== 6'd0 || hazard !== 1'b0) begin
         fails++;
         $display("FAIL reset_after_fill got cnt=%0d hazard=%b want cnt=0 hazard=0", busy_cnt, hazard);
      end
      for (int a = 0; a < NREGS; a++) begin
         set_rd(AW'(a), AW'(a));
         tests++;
         if (rd_data !== '0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_clear addr=%0d got data=%h busy=%b want data=0 busy=00", a, rd_data, rd_busy);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      rd_addr = '0;
      test_reset();
      test_write_read();
      test_reserve_writeback();
      test_resv_wr_same_cycle();
      test_bypass();
      test_fill_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
